load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a 32x32-bit word memory: SW is one write, SB/SH are
// read-modify-write, loads read then extract and extend a lane; bad accesses never touch memory.
module load_store_unit #(
    parameter int DM_AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             resp_valid,
    output logic [31:0]      rdata,
    output logic             err,
    output logic [DM_AW-1:0] dm_address,
    output logic [31:0]      dm_wd,
    output logic             dm_we,
    input  logic [31:0]      dm_rd
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  a_q;
    logic [2:0]  f3_q;
    logic        we_q;
    logic [31:0] wd_q;

    logic        legal;
    logic        misaligned;
    logic        is_sw;
    logic [31:0] merged;
    logic [31:0] extracted;
    logic        unused_addr_hi;

    // Upper address bits only select an alias of the same memory word.
    assign unused_addr_hi = ^addr[31:DM_AW+2];

    always_comb begin
        legal = 1'b0;
        if (req_we) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end
    end

    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign is_sw      = req_we && (funct3 == 3'b010);

    // Replace the addressed byte/half of the word just read with the low store data.
    always_comb begin
        merged = dm_rd;
        case (f3_q[1:0])
            2'b00:   merged[{a_q, 3'b000} +: 8]        = wd_q[7:0];
            2'b01:   merged[{a_q[1], 4'b0000} +: 16]   = wd_q[15:0];
            default: merged = wd_q;
        endcase
    end

    always_comb begin
        extracted = dm_rd;
        case (f3_q)
            3'b000:  extracted = {{24{dm_rd[{a_q, 3'b111}]}}, dm_rd[{a_q, 3'b000} +: 8]};
            3'b100:  extracted = {24'd0, dm_rd[{a_q, 3'b000} +: 8]};
            3'b001:  extracted = {{16{dm_rd[{a_q[1], 4'b1111}]}}, dm_rd[{a_q[1], 4'b0000} +: 16]};
            3'b101:  extracted = {16'd0, dm_rd[{a_q[1], 4'b0000} +: 16]};
            default: extracted = dm_rd;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    // Gating with rst_n keeps a reset edge from committing a half-finished store.
    assign dm_we      = (state == WRITE) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= 2'd0;
            f3_q       <= 3'd0;
            we_q       <= 1'b0;
            wd_q       <= 32'd0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            dm_address <= '0;
            dm_wd      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q  <= addr[1:0];
                        f3_q <= funct3;
                        we_q <= req_we;
                        wd_q <= wdata;
                        err  <= 1'b0;
                        if (!legal || misaligned) begin
                            state <= ERR;
                        end else if (is_sw) begin
                            dm_address <= addr[DM_AW+1:2];
                            dm_wd      <= wdata;
                            state      <= WRITE;
                        end else begin
                            dm_address <= addr[DM_AW+1:2];
                            state      <= READ;
                        end
                    end
                end
                READ:  state <= DATA;
                DATA: begin
                    if (we_q) begin
                        dm_wd <= merged;
                        state <= WRITE;
                    end else begin
                        rdata <= extracted;
                        state <= RESP;
                    end
                end
                WRITE: state <= RESP;
                ERR: begin
                    err   <= 1'b1;
                    rdata <= 32'd0;
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a synchronous-read word memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic [4:0]  dm_address;
    logic [31:0] dm_wd;
    logic        dm_we;
    logic [31:0] dm_rd;

    logic [31:0] mem [0:31];

    int checks = 0;
    int errors = 0;

    load_store_unit #(.DM_AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .err        (err),
        .dm_address (dm_address),
        .dm_wd      (dm_wd),
        .dm_we      (dm_we),
        .dm_rd      (dm_rd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        dm_rd = 32'd0;
    end

    always @(posedge clk) begin
        if (dm_we) mem[dm_address] <= dm_wd;
        dm_rd <= mem[dm_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request; exp_we_cyc = 0 means no memory write may occur.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_we_cyc, input logic [4:0] exp_wa,
                          input logic [31:0] exp_wdv);
        int lat;
        int we_cyc;
        int we_cnt;
        logic [4:0]  wa;
        logic [31:0] wv;
        lat = 0; we_cyc = 0; we_cnt = 0; wa = '0; wv = '0;
        @(negedge clk);
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (dm_we) begin
                if (we_cnt == 0) begin
                    we_cyc = n; wa = dm_address; wv = dm_wd;
                end
                we_cnt++;
            end
            if (resp_valid) begin
                lat = n;
                check({tag, ".rdata"}, rdata, exp_rd);
                check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
                break;
            end
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".we_cycle"}, we_cyc, exp_we_cyc);
        if (exp_we_cyc != 0) begin
            check({tag, ".we_count"}, we_cnt, 1);
            check({tag, ".we_addr"}, {27'd0, wa}, {27'd0, exp_wa});
            check({tag, ".we_data"}, wv, exp_wdv);
        end
        @(negedge clk);
        check({tag, ".resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    logic [6:0]  rdy_bits;
    logic [6:0]  rsp_bits;
    logic [31:0] rd_b2b;
    logic [4:0]  wa_b2b;
    logic [31:0] wd_b2b;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp",  {31'd0, resp_valid}, 32'd0);
        check("rst.err",   {31'd0, err}, 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.dm_address", {27'd0, dm_address}, 32'd0);
        check("rst.dm_wd", dm_wd, 32'd0);
        check("rst.dm_we", {31'd0, dm_we}, 32'd0);
        rst_n = 1'b1;

        // word store / load
        do_req("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0,        0, 1, 5'd4, 32'hDEADBEEF);
        do_req("lw10", 0, 3'b010, 32'h10, 32'h0,       3, 32'hDEADBEEF, 0, 0, 5'd0, 32'h0);
        // sub-word read-modify-write
        do_req("sb12", 1, 3'b000, 32'h12, 32'h00000055, 4, 32'hDEADBEEF, 0, 3, 5'd4, 32'hDE55BEEF);
        do_req("sh10", 1, 3'b001, 32'h10, 32'h00001234, 4, 32'hDEADBEEF, 0, 3, 5'd4, 32'hDE551234);
        check("mem4.rmw", mem[4], 32'hDE551234);
        // load extension
        do_req("sw_ext", 1, 3'b010, 32'h10, 32'h80FF7F01, 2, 32'hDEADBEEF, 0, 1, 5'd4, 32'h80FF7F01);
        do_req("lb13",  0, 3'b000, 32'h13, 32'h0, 3, 32'hFFFFFF80, 0, 0, 5'd0, 32'h0);
        do_req("lbu13", 0, 3'b100, 32'h13, 32'h0, 3, 32'h00000080, 0, 0, 5'd0, 32'h0);
        do_req("lh12",  0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFF80FF, 0, 0, 5'd0, 32'h0);
        do_req("lhu10", 0, 3'b101, 32'h10, 32'h0, 3, 32'h00007F01, 0, 0, 5'd0, 32'h0);
        do_req("lb10",  0, 3'b000, 32'h10, 32'h0, 3, 32'h00000001, 0, 0, 5'd0, 32'h0);
        do_req("lbu11", 0, 3'b100, 32'h11, 32'h0, 3, 32'h0000007F, 0, 0, 5'd0, 32'h0);
        // misaligned / illegal
        do_req("lw11_mis",  0, 3'b010, 32'h11, 32'h0,        2, 32'h0, 1, 0, 5'd0, 32'h0);
        do_req("sh13_mis",  1, 3'b001, 32'h13, 32'hFFFFFFFF, 2, 32'h0, 1, 0, 5'd0, 32'h0);
        do_req("st100_ill", 1, 3'b100, 32'h10, 32'hFFFFFFFF, 2, 32'h0, 1, 0, 5'd0, 32'h0);
        do_req("ld011_ill", 0, 3'b011, 32'h10, 32'h0,        2, 32'h0, 1, 0, 5'd0, 32'h0);
        check("mem4.after_err", mem[4], 32'h80FF7F01);
        do_req("lw_clr", 0, 3'b010, 32'h10, 32'h0, 3, 32'h80FF7F01, 0, 0, 5'd0, 32'h0);

        // back-to-back with req_valid held high
        rd_b2b = '0; wa_b2b = '0; wd_b2b = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        @(posedge clk);
        #1 req_we = 1'b1; addr = 32'h14; wdata = 32'hA5A5A5A5;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            rdy_bits[i] = req_ready;
            rsp_bits[i] = resp_valid;
            if (i == 2) rd_b2b = rdata;
            if (i == 4) begin
                wa_b2b = dm_address; wd_b2b = dm_wd;
                req_valid = 1'b0;
            end
        end
        check("b2b.ready_seq", {25'd0, rdy_bits}, {25'd0, 7'b1001000});
        check("b2b.resp_seq",  {25'd0, rsp_bits}, {25'd0, 7'b0100100});
        check("b2b.rdata", rd_b2b, 32'h80FF7F01);
        check("b2b.we_addr", {27'd0, wa_b2b}, 32'd5);
        check("b2b.we_data", wd_b2b, 32'hA5A5A5A5);
        check("mem5.b2b", mem[5], 32'hA5A5A5A5);

        // reset during the WRITE cycle of an SB
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b000; addr = 32'h14; wdata = 32'h00000011;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rmw_rst.we_before", {31'd0, dm_we}, 32'd1);
        check("rmw_rst.wd_before", dm_wd, 32'hA5A5A511);
        rst_n = 1'b0;
        @(negedge clk);
        check("rmw_rst.ready", {31'd0, req_ready}, 32'd1);
        check("rmw_rst.resp",  {31'd0, resp_valid}, 32'd0);
        check("rmw_rst.err",   {31'd0, err}, 32'd0);
        check("rmw_rst.rdata", rdata, 32'd0);
        check("rmw_rst.dm_address", {27'd0, dm_address}, 32'd0);
        check("rmw_rst.dm_wd", dm_wd, 32'd0);
        check("rmw_rst.dm_we", {31'd0, dm_we}, 32'd0);
        check("rmw_rst.mem5", mem[5], 32'hA5A5A5A5);
        rst_n = 1'b1;
        @(negedge clk);
        check("rmw_rst.resp_after", {31'd0, resp_valid}, 32'd0);
        do_req("lw14_rb", 0, 3'b010, 32'h14, 32'h0, 3, 32'hA5A5A5A5, 0, 0, 5'd0, 32'h0);

        // address wrap
        do_req("sw80_wrap", 1, 3'b010, 32'h80, 32'h0BADF00D, 2, 32'hA5A5A5A5, 0, 1, 5'd0, 32'h0BADF00D);
        check("mem0.wrap", mem[0], 32'h0BADF00D);
        do_req("lw00", 0, 3'b010, 32'h0, 32'h0, 3, 32'h0BADF00D, 0, 0, 5'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
